// File: rtl/seg7_if.sv
// Bundle between the value-producing logic and the seven-segment scan driver.
// The producer side is the master; the driver itself is the slave.
interface seg7_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
    logic                  dec_mode;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     dig_en;
    logic                  frame;
    logic                  load_ack;
    logic                  pending;

    modport master (
        output load, data, dp_in, blank_in, dec_mode,
        input  seg, dp, dig_en, frame, load_ack, pending
    );

    modport slave (
        input  load, data, dp_in, blank_in, dec_mode,
        output seg, dp, dig_en, frame, load_ack, pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: shadow/active digit registers swapped at
// frame boundaries, hex/decimal decode, guard-banded digit scan.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int DIV         = 1000,
    parameter int GUARD       = 2,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit DIG_ACT_LOW = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    seg7_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACT_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACT_LOW}};

    logic [PW-1:0]            p;
    logic [KW-1:0]            k;
    logic [DIGITS-1:0][3:0]   sh_data, act_data;
    logic [DIGITS-1:0]        sh_dp, sh_blank, act_dp, act_blank;
    logic                     pend;
    logic                     p_last, boundary;

    logic [6:0]               seg_q, seg_n;
    logic                     dp_q, dp_n;
    logic [DIGITS-1:0]        dig_q, dig_n;
    logic                     frame_q, ack_q;

    function automatic logic [6:0] decode(input logic [3:0] nib, input logic dec);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        // Decimal mode shows a minus sign for anything that is not a digit
        if (dec && nib > 4'd9) s = 7'h40;
        return s;
    endfunction

    assign p_last   = (p == PW'(DIV - 1));
    assign boundary = p_last && (k == KW'(DIGITS - 1));

    // Logical (pre-inversion) outputs for the current counter state
    always_comb begin
        seg_n = 7'h00;
        dp_n  = 1'b0;
        dig_n = '0;
        if (p >= PW'(GUARD)) begin
            dig_n[k] = 1'b1;
            if (!act_blank[k]) begin
                seg_n = decode(act_data[k], bus.dec_mode);
                dp_n  = act_dp[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p         <= '0;
            k         <= '0;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            pend      <= 1'b0;
            frame_q   <= 1'b0;
            ack_q     <= 1'b0;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
            dig_q     <= DIG_OFF;
        end else begin
            p <= p_last ? '0 : p + 1'b1;
            if (p_last)
                k <= (k == KW'(DIGITS - 1)) ? '0 : k + 1'b1;

            frame_q <= boundary;
            ack_q   <= boundary && (bus.load || pend);

            // A load landing on the boundary goes straight to active
            if (bus.load && boundary) begin
                act_data  <= bus.data;
                act_dp    <= bus.dp_in;
                act_blank <= bus.blank_in;
                pend      <= 1'b0;
            end else if (bus.load) begin
                sh_data   <= bus.data;
                sh_dp     <= bus.dp_in;
                sh_blank  <= bus.blank_in;
                pend      <= 1'b1;
            end else if (boundary && pend) begin
                act_data  <= sh_data;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
                pend      <= 1'b0;
            end

            seg_q <= seg_n ^ SEG_OFF;
            dp_q  <= dp_n ^ DP_OFF;
            dig_q <= dig_n ^ DIG_OFF;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.dig_en   = dig_q;
    assign bus.frame    = frame_q;
    assign bus.load_ack = ack_q;
    assign bus.pending  = pend;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, DIV=8, GUARD=2) plus an
// inverted-polarity instance sharing clock and reset.
module tb_seg7_scan_driver;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   n;   // edges since reset release; outputs after edge n reflect counter cycle n-1

    seg7_if #(.DIGITS(4)) bus  ();
    seg7_if #(.DIGITS(4)) bus2 ();

    seg7_scan_driver #(.DIGITS(4), .DIV(8), .GUARD(2), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0))
        dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    seg7_scan_driver #(.DIGITS(4), .DIV(8), .GUARD(2), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic drive(input logic ld, input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] blk);
        bus.load     = ld;
        bus.data     = d;
        bus.dp_in    = dpv;
        bus.blank_in = blk;
    endtask

    initial begin
        logic [31:0] exp_dig;
        logic [31:0] exp_seg;
        vectors = 0; miscompares = 0; n = 0;
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 4'h0, 4'h0);
        bus.dec_mode = 1'b0;
        bus2.load = 1'b0; bus2.data = 16'h0000; bus2.dp_in = 4'h0;
        bus2.blank_in = 4'h0; bus2.dec_mode = 1'b0;

        // Reset and idle
        repeat (3) step();
        chk("rst_seg",     bus.seg, 7'h00);
        chk("rst_dig",     bus.dig_en, 4'h0);
        chk("rst_frame",   bus.frame, 1'b0);
        chk("rst_pending", bus.pending, 1'b0);
        chk("rst_seg_inv", bus2.seg, 7'h7F);
        chk("rst_dig_inv", bus2.dig_en, 4'hF);
        chk("rst_dp_inv",  bus2.dp, 1'b1);
        rst_n = 1'b1;
        n = 0;

        for (int i = 0; i < 32; i++) begin
            bus2.load = (n == 5);
            bus2.data = 16'h0008;
            step();
            exp_dig = (((n - 1) % 8) < 2) ? 32'h0 : (32'h1 << ((n - 1) / 8));
            exp_seg = (((n - 1) % 8) < 2) ? 32'h00 : 32'h3F;
            chk("idle_dig",   bus.dig_en, exp_dig);
            chk("idle_seg",   bus.seg, exp_seg);
            chk("idle_frame", bus.frame, (n == 32) ? 32'h1 : 32'h0);
            if (n == 6) chk("inv_pending", bus2.pending, 1'b1);
        end
        chk("idle_ack_none", bus.load_ack, 1'b0);
        chk("inv_ack", bus2.load_ack, 1'b1);

        // Polarity: guard then digit 0 showing 8
        step();
        chk("inv_guard_seg", bus2.seg, 7'h7F);
        chk("inv_guard_dig", bus2.dig_en, 4'hF);
        run_to(35);
        chk("inv_d0_seg", bus2.seg, 7'h00);
        chk("inv_d0_dig", bus2.dig_en, 4'hE);
        chk("inv_d0_dp",  bus2.dp, 1'b1);
        run_to(43);
        chk("inv_d1_seg", bus2.seg, 7'h40);
        chk("inv_d1_dig", bus2.dig_en, 4'hD);

        // Load at p=3,k=1 (counter cycle 43)
        drive(1'b1, 16'h1234, 4'h0, 4'h0);
        step();
        drive(1'b0, 16'h0000, 4'h0, 4'h0);
        chk("ld_pending", bus.pending, 1'b1);
        run_to(51);
        chk("ld_cur_seg", bus.seg, 7'h3F);
        chk("ld_cur_dig", bus.dig_en, 4'h4);
        run_to(63);
        chk("ld_pend_pre", bus.pending, 1'b1);
        chk("ld_ack_pre",  bus.load_ack, 1'b0);
        step();
        chk("ld_ack",      bus.load_ack, 1'b1);
        chk("ld_frame",    bus.frame, 1'b1);
        chk("ld_pend_clr", bus.pending, 1'b0);
        step();
        chk("ld_guard_seg", bus.seg, 7'h00);
        chk("ld_guard_dig", bus.dig_en, 4'h0);
        chk("ld_ack_once",  bus.load_ack, 1'b0);
        run_to(67);  chk("ld_d0", bus.seg, 7'h66); chk("ld_d0_dig", bus.dig_en, 4'h1);
        run_to(75);  chk("ld_d1", bus.seg, 7'h4F);
        run_to(83);  chk("ld_d2", bus.seg, 7'h5B);
        run_to(91);  chk("ld_d3", bus.seg, 7'h06); chk("ld_d3_dig", bus.dig_en, 4'h8);

        // Decimal mode and blanking
        run_to(101);
        drive(1'b1, 16'hAB90, 4'b0001, 4'b0100);
        bus.dec_mode = 1'b1;
        step();
        drive(1'b0, 16'h0000, 4'h0, 4'h0);
        run_to(128);
        chk("dec_ack", bus.load_ack, 1'b1);
        run_to(131);
        chk("dec_d0",    bus.seg, 7'h3F);
        chk("dec_d0_dp", bus.dp, 1'b1);
        run_to(139);
        chk("dec_d1",    bus.seg, 7'h6F);
        chk("dec_d1_dp", bus.dp, 1'b0);
        run_to(147);
        chk("blank_dig", bus.dig_en, 4'h4);
        chk("blank_seg", bus.seg, 7'h00);
        chk("blank_dp",  bus.dp, 1'b0);
        run_to(155);
        chk("dec_d3", bus.seg, 7'h40);
        bus.dec_mode = 1'b0;
        chk("dec_d3_hold", bus.seg, 7'h40);
        step();
        chk("hex_d3", bus.seg, 7'h77);

        // Bypass: load in the boundary cycle (counter cycle 159)
        run_to(159);
        drive(1'b1, 16'h00F0, 4'h0, 4'h0);
        step();
        drive(1'b0, 16'h0000, 4'h0, 4'h0);
        chk("byp_ack",     bus.load_ack, 1'b1);
        chk("byp_frame",   bus.frame, 1'b1);
        chk("byp_pending", bus.pending, 1'b0);
        step();
        chk("byp_pending2", bus.pending, 1'b0);
        run_to(163); chk("byp_d0", bus.seg, 7'h3F);
        run_to(171); chk("byp_d1", bus.seg, 7'h71); chk("byp_d1_dig", bus.dig_en, 4'h2);

        // Back-to-back loads: last one wins
        run_to(195);
        drive(1'b1, 16'h1111, 4'h0, 4'h0);
        step();
        drive(1'b0, 16'h0000, 4'h0, 4'h0);
        run_to(200);
        drive(1'b1, 16'h2222, 4'h0, 4'h0);
        step();
        drive(1'b0, 16'h0000, 4'h0, 4'h0);
        run_to(224);
        chk("b2b_ack", bus.load_ack, 1'b1);
        run_to(227); chk("b2b_d0", bus.seg, 7'h5B);
        run_to(235); chk("b2b_d1", bus.seg, 7'h5B);
        run_to(243); chk("b2b_d2", bus.seg, 7'h5B);
        run_to(251); chk("b2b_d3", bus.seg, 7'h5B);

        // Mid-scan reset discards pending data
        run_to(260);
        drive(1'b1, 16'h3333, 4'h0, 4'h0);
        step();
        drive(1'b0, 16'h0000, 4'h0, 4'h0);
        chk("mr_pending", bus.pending, 1'b1);
        run_to(265);
        rst_n = 1'b0;
        step();
        step();
        chk("mr_rst_seg",  bus.seg, 7'h00);
        chk("mr_rst_dig",  bus.dig_en, 4'h0);
        chk("mr_rst_pend", bus.pending, 1'b0);
        rst_n = 1'b1;
        n = 0;
        run_to(2);  chk("mr_guard2", bus.dig_en, 4'h0);
        run_to(3);  chk("mr_d0", bus.seg, 7'h3F); chk("mr_d0_dig", bus.dig_en, 4'h1);
        run_to(11); chk("mr_d1", bus.seg, 7'h3F);
        run_to(31); chk("mr_frame_pre", bus.frame, 1'b0);
        step();
        chk("mr_frame", bus.frame, 1'b1);
        chk("mr_noack", bus.load_ack, 1'b0);
        run_to(51);
        chk("mr_d2", bus.seg, 7'h3F);
        chk("mr_pend_end", bus.pending, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
